// File: rtl/mdu_iter_pkg.sv
// mdu_iter_pkg: shared width, RV32M op encodings and FSM states for the iterative MDU.
package mdu_iter_pkg;
    localparam int XLEN = 32;
    localparam int CW = $clog2(XLEN) + 1;
    typedef enum logic [2:0] {
        MDU_MUL    = 3'b000,
        MDU_MULH   = 3'b001,
        MDU_MULHSU = 3'b010,
        MDU_MULHU  = 3'b011,
        MDU_DIV    = 3'b100,
        MDU_DIVU   = 3'b101,
        MDU_REM    = 3'b110,
        MDU_REMU   = 3'b111
    } op_t;
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIN} state_t;
endpackage

// File: rtl/mdu_iter_if.sv
// mdu_iter_if: request/write-back bundle between register file, control and the MDU.
interface mdu_iter_if;
    import mdu_iter_pkg::*;
    logic start;
    logic flush;
    logic [2:0] op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [4:0] rd_in;
    logic busy;
    logic done;
    logic [XLEN-1:0] result;
    logic [4:0] rd_out;
    logic wb_we;
    modport master (output start, flush, op, a, b, rd_in, input busy, done, result, rd_out, wb_we);
    modport slave (input start, flush, op, a, b, rd_in, output busy, done, result, rd_out, wb_we);
endinterface

// File: rtl/mdu_iter_step.sv
// mdu_step: one radix-2 iteration, shift-add multiply or restoring divide on magnitudes.
module mdu_step
    import mdu_iter_pkg::*;
(
    input  logic            div,
    input  logic [XLEN-1:0] acc,
    input  logic [XLEN-1:0] sh,
    input  logic [XLEN-1:0] m,
    output logic [XLEN-1:0] acc_n,
    output logic [XLEN-1:0] sh_n
);
    logic [XLEN:0] sum;
    logic [XLEN:0] shl;
    logic [XLEN:0] dif;
    // Partial remainder stays below 2*m, so the borrow bit alone says whether m fits.
    always_comb begin
        sum = {1'b0, acc} + (sh[0] ? {1'b0, m} : '0);
        shl = {acc, sh[XLEN-1]};
        dif = shl - {1'b0, m};
        acc_n = div ? (dif[XLEN] ? shl[XLEN-1:0] : dif[XLEN-1:0]) : sum[XLEN:1];
        sh_n = div ? {sh[XLEN-2:0], ~dif[XLEN]} : {sum[0], sh[XLEN-1:1]};
    end
endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: fixed-latency iterative RV32M multiply/divide unit with register-file write-back.
module mdu_iter
    import mdu_iter_pkg::*;
(
    input logic clk,
    input logic rst,
    mdu_iter_if.slave bus
);
    state_t state;
    logic [CW-1:0] cnt;
    logic [2:0] op_r;
    logic [XLEN-1:0] acc, sh, m, acc_n, sh_n, force_val, ma, mb, fv, res, result;
    logic [2*XLEN-1:0] prod;
    logic [4:0] rd_out;
    logic sa, sb, sa_r, sb_r, frc, frc_r, as, bs, done;
    // Operand signedness, magnitudes and the div-by-zero / overflow results are fixed at accept.
    always_comb begin
        as = bus.op[2] ? !bus.op[0] : bus.op[1:0] != 2'b11;
        bs = bus.op[2] ? !bus.op[0] : !bus.op[1];
        sa = as && bus.a[XLEN-1];
        sb = bs && bus.b[XLEN-1];
        ma = sa ? -bus.a : bus.a;
        mb = sb ? -bus.b : bus.b;
        frc = bus.op[2] && (bus.b == '0 || (bs && bus.a == {1'b1, {(XLEN-1){1'b0}}} && bus.b == '1));
        fv = bus.b == '0 ? (bus.op[1] ? bus.a : '1) : (bus.op[1] ? '0 : bus.a);
    end
    mdu_step u_step (.div(op_r[2]), .acc(acc), .sh(sh), .m(m), .acc_n(acc_n), .sh_n(sh_n));
    always_comb begin
        prod = (sa_r ^ sb_r) ? -{acc, sh} : {acc, sh};
        res = frc_r ? force_val
            : !op_r[2] ? (op_r[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN])
            : op_r[1] ? (sa_r ? -acc : acc)
            : ((sa_r ^ sb_r) ? -sh : sh);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt <= '0;
            op_r <= '0;
            acc <= '0;
            sh <= '0;
            m <= '0;
            sa_r <= 1'b0;
            sb_r <= 1'b0;
            frc_r <= 1'b0;
            force_val <= '0;
            result <= '0;
            rd_out <= '0;
            done <= 1'b0;
        end else if (state != ST_IDLE && bus.flush) begin
            state <= ST_IDLE;
            done <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (bus.start && !bus.flush) begin
                        state <= ST_RUN;
                        cnt <= '0;
                        op_r <= bus.op;
                        acc <= '0;
                        sh <= ma;
                        m <= mb;
                        sa_r <= sa;
                        sb_r <= sb;
                        frc_r <= frc;
                        force_val <= fv;
                        rd_out <= bus.rd_in;
                    end
                end
                ST_RUN: begin
                    if (cnt == CW'(XLEN)) begin
                        state <= ST_FIN;
                        result <= res;
                        done <= 1'b1;
                    end else begin
                        acc <= acc_n;
                        sh <= sh_n;
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_FIN: begin
                    state <= ST_IDLE;
                    done <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
    assign bus.busy = state != ST_IDLE;
    assign bus.done = done;
    assign bus.result = result;
    assign bus.rd_out = rd_out;
    // A flush landing in the done cycle must still suppress the register write.
    assign bus.wb_we = done && rd_out != '0 && !bus.flush;
endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: directed and randomized checks of mdu_iter against a 64-bit arithmetic model.
module tb_mdu_iter;
    import mdu_iter_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int errors = 0;
    int checks = 0;
    mdu_iter_if bus ();
    mdu_iter dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    function automatic logic [31:0] model(logic [2:0] op, logic [31:0] a, logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'({32'h0, a});
        longint ub = longint'({32'h0, b});
        logic [63:0] p;
        logic ovf = a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
        case (op)
            3'd0: begin p = 64'(sa * sb); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = 64'(ua * ub); return p[63:32]; end
            3'd4: return b == 0 ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
            3'd5: return b == 0 ? 32'hFFFF_FFFF : a / b;
            3'd6: return b == 0 ? a : ovf ? 32'h0 : 32'(sa % sb);
            default: return b == 0 ? a : a % b;
        endcase
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(logic [2:0] op, logic [31:0] a, logic [31:0] b, logic [4:0] rd);
        bus.start = 1'b1;
        bus.op = op;
        bus.a = a;
        bus.b = b;
        bus.rd_in = rd;
        tick();
        bus.start = 1'b0;
        bus.a = $urandom;
        bus.b = $urandom;
        bus.rd_in = 5'($urandom);
    endtask

    // Waits for done with a bound; returns edges counted after the accepting edge.
    task automatic wait_done(output int n);
        n = 0;
        while (!bus.done && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic run_op(string tag, logic [2:0] op, logic [31:0] a, logic [31:0] b, logic [4:0] rd);
        int n;
        logic [31:0] exp = model(op, a, b);
        launch(op, a, b, rd);
        wait_done(n);
        chk({tag, " latency"}, 32'(n), 32'd33);
        chk({tag, " busy"}, 32'(bus.busy), 32'd1);
        chk({tag, " result"}, bus.result, exp);
        chk({tag, " rd_out"}, 32'(bus.rd_out), 32'(rd));
        chk({tag, " wb_we"}, 32'(bus.wb_we), 32'(rd != 0));
        tick();
        chk({tag, " done drop"}, 32'(bus.done), 32'd0);
        chk({tag, " idle"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int n;
        int dn;
        logic [2:0] op;
        logic [31:0] a;
        logic [31:0] b;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.op = '0;
        bus.a = '0;
        bus.b = '0;
        bus.rd_in = '0;
        #1;
        chk("rst busy", 32'(bus.busy), 32'd0);
        chk("rst done", 32'(bus.done), 32'd0);
        chk("rst wb_we", 32'(bus.wb_we), 32'd0);
        chk("rst result", bus.result, 32'd0);
        chk("rst rd_out", 32'(bus.rd_out), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        run_op("mul", MDU_MUL, 32'd7, 32'hFFFF_FFFD, 5'd5);
        run_op("mulh", MDU_MULH, 32'h8000_0000, 32'h8000_0000, 5'd1);
        run_op("mulhu", MDU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
        run_op("mulhsu", MDU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
        run_op("div", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 5'd4);
        run_op("rem", MDU_REM, 32'hFFFF_FFF9, 32'd2, 5'd6);
        run_op("divu", MDU_DIVU, 32'd100, 32'd7, 5'd7);
        run_op("remu", MDU_REMU, 32'd100, 32'd7, 5'd8);
        run_op("div0", MDU_DIV, 32'd5, 32'd0, 5'd9);
        run_op("remu0", MDU_REMU, 32'd5, 32'd0, 5'd10);
        run_op("divovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);
        run_op("removf", MDU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);
        // Start during the done cycle must be dropped rather than queued.
        launch(MDU_MULHU, 32'd9, 32'd9, 5'd13);
        wait_done(n);
        chk("fin start lat", 32'(n), 32'd33);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("fin start ignored", 32'(bus.busy), 32'd0);
        tick();
        // Flush in the done cycle kills the write enable immediately.
        launch(MDU_DIVU, 32'd100, 32'd7, 5'd3);
        wait_done(n);
        bus.flush = 1'b1;
        #1;
        chk("fin flush wb_we", 32'(bus.wb_we), 32'd0);
        tick();
        bus.flush = 1'b0;
        chk("fin flush idle", 32'(bus.busy), 32'd0);
        // Second start ignored mid-run, then flush aborts with no done.
        launch(MDU_DIVU, 32'd1000, 32'd3, 5'd14);
        dn = 0;
        for (int i = 1; i < 10; i++) begin
            if (i == 5) bus.start = 1'b1;
            if (i == 5) bus.op = MDU_MUL;
            tick();
            bus.start = 1'b0;
            dn += int'(bus.done);
        end
        chk("second start busy", 32'(bus.busy), 32'd1);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        dn += int'(bus.done);
        chk("flush busy", 32'(bus.busy), 32'd0);
        chk("flush no done", 32'(dn), 32'd0);
        run_op("mul rd0", MDU_MUL, 32'd3, 32'd4, 5'd0);
        // Asynchronous reset mid-division.
        launch(MDU_DIV, 32'h1234_5678, 32'd77, 5'd15);
        repeat (19) tick();
        #2 rst = 1'b1;
        #1;
        chk("arst busy", 32'(bus.busy), 32'd0);
        chk("arst done", 32'(bus.done), 32'd0);
        chk("arst wb_we", 32'(bus.wb_we), 32'd0);
        tick();
        rst = 1'b0;
        dn = 0;
        repeat (40) begin
            tick();
            dn += int'(bus.done);
        end
        chk("arst no done", 32'(dn), 32'd0);
        for (int i = 0; i < 30; i++) begin
            op = 3'($urandom);
            a = $urandom_range(3, 0) == 0 ? 32'h8000_0000 : $urandom;
            case ($urandom_range(4, 0))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: b = $urandom_range(15, 1);
                default: b = $urandom;
            endcase
            run_op($sformatf("rand%0d op%0d", i, op), op, a, b, 5'($urandom));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
